uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter with an integrated TX FIFO, runtime baud divisor,
//   configurable data width, parity and stop bits. Sits between the sensor-hub packet
//   formatter and the board TX pin. It replaces the single-byte fixed-8N1 transmitter.
//   Each frame restarts its own bit timer, so start-bit timing is exact: no tick jitter.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock frequency (Hz)
//   BAUD       115200      default baud; DIV = CLK_HZ/BAUD, used when baud_div==0
//   DATA_W     8           data bits per frame, legal 5..9
//   PARITY     0           0 none, 1 even, 2 odd (encodings in uart_pkg)
//   STOP_BITS  1           1 or 2
//   FIFO_DEPTH 4           TX FIFO entries, power of two, >=2
// PORTS
//   clk        in   1               system clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   data       in   DATA_W          word to send, LSB first
//   valid      in   1               producer offers data
//   ready      out  1               FIFO not full; push when valid&&ready
//   baud_div   in   16              clocks per bit; 0 -> DIV; 1 clamps to 2
//   tx         out  1               serial line, idle high, registered
//   busy       out  1               frame in progress (state != IDLE)
//   level      out  $clog2(DEPTH)+1 FIFO occupancy, 0..FIFO_DEPTH
//   frame_done out  1               1-cycle pulse on the last cycle of the final stop bit
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): tx=1, busy=0, frame_done=0, level=0,
//     ready=1, FIFO flushed, state IDLE, bit timer 0. The partial frame is abandoned.
//   FIFO: push on valid&&ready. ready = (level!=FIFO_DEPTH), combinational from level.
//     Pop only in IDLE->START or STOP->START transitions. Push and pop in the same cycle
//     leave level unchanged. valid while ready=0 is ignored; the producer holds data.
//   Bit period P: baud_div, or DIV if 0, or 2 if 1. P is latched at pop and held for
//     the whole frame; baud_div changes affect the next frame only.
//   FSM: IDLE, START, DATA, PAR, STOP. The timer counts 0..P-1 in each bit.
//     IDLE : if level!=0, pop and latch word/P -> START. tx<=0 on the same edge.
//            Latency from push into an empty FIFO to tx falling: 1 clock.
//     START: after P cycles -> DATA, tx<=d[0].
//     DATA : DATA_W bits LSB first, P cycles each; then -> PAR (if PARITY!=0) else STOP.
//     PAR  : tx = ^word (even) or ~^word (odd), for P cycles.
//     STOP : tx=1 for STOP_BITS*P cycles. On the last cycle frame_done=1.
//            If level!=0, pop -> START with no idle gap. Otherwise -> IDLE.
//   Frame length = (1+DATA_W+(PARITY!=0)+STOP_BITS)*P clocks exactly.
//   Width rules: timer 16 bits, bit index $clog2(DATA_W+1) bits, level has no wrap.
//     FIFO pointers wrap modulo FIFO_DEPTH.
//   busy=1 from the edge tx falls until the STOP->IDLE edge.
// STRUCTURE
//   uart_pkg: state encodings, PARITY_NONE/EVEN/ODD constants, clamp helper for the divisor.
//   Sub-module sync_fifo (DATA_W x FIFO_DEPTH, async active-low reset, level output),
//     instantiated once. The FSM, bit timer and shifter stay in this module.
// TESTING
//   8E1, baud_div=4, push 0xA5 -> tx: 0, 1,0,1,0,0,1,0,1, par 0, stop 1; 4 clk each,
//     44 clk total, frame_done at clk 44.
//   8O2, baud_div=3, push 0x00 -> parity bit 1, stop high 6 clk, frame 36 clk.
//   Depth 4, baud_div=4, push 6 words back-to-back -> 5 accepted, then ready=0;
//     frames have no idle gap; level returns to 0; all words in order.
//   baud_div=0 -> 434 clk/bit at defaults. baud_div=1 -> 2 clk/bit.
//     Change baud_div mid-frame -> current frame keeps its old P.
//   Assert rst_n low in the middle of a data bit -> tx=1, busy=0, level=0 immediately.
//     Next push sends a clean frame.
//   DATA_W=5, PARITY=0 -> push 0x1F -> 7*P clk frame, upper input bits ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, parity modes
// and the helpers that resolve the bit period and the parity bit.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [15:0] MIN_DIV = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // 0 selects the build-time divisor; 1 cannot give a mid-bit, so it is raised to 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] req, input logic [15:0] dflt);
        logic [15:0] res;
        if (req == 16'd0) begin
            res = dflt;
        end else if (req == 16'd1) begin
            res = MIN_DIV;
        end else begin
            res = req;
        end
        return res;
    endfunction

    // Words are zero-extended to 9 bits; zero padding leaves the parity unchanged.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        logic res;
        if (mode == PARITY_ODD) begin
            res = ~^word;
        end else begin
            res = ^word;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding words waiting for transmission; exposes its occupancy.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push_i && (level_q != FULL);
    assign do_pop_s  = pop_i && (level_q != '0);
    assign rdata_o   = mem_q[rptr_q];
    assign level_o   = level_q;

    // Storage, wrap-around pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; the bit period is sampled per frame so a
// divisor change never disturbs the frame currently on the line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             data,
    input  logic                          valid,
    output logic                          ready,
    input  logic [15:0]                   baud_div,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_done
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [15:0]      DIV       = 16'(CLK_HZ / BAUD);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       per_q, per_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q;
    logic              done_q, done_d;

    logic              push_s;
    logic              pop_s;
    logic              bit_end_s;
    logic [DATA_W-1:0] fifo_rdata_s;
    logic [LVL_W-1:0]  level_s;

    assign ready      = (level_s != LVL_W'(FIFO_DEPTH));
    assign push_s     = valid && ready;
    assign bit_end_s  = (timer_q == per_q - 16'd1);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign level      = level_s;
    assign frame_done = done_q;

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (data),
        .rdata_o (fifo_rdata_s),
        .level_o (level_s)
    );

    // Frame sequencing: bit timer, shifter and next line level.
    always_comb begin
        state_d = state_q;
        timer_d = 16'd0;
        per_d   = per_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop_s   = 1'b0;
        if (state_q != ST_IDLE && !bit_end_s) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = 16'd0;
        end
        case (state_q)
            ST_IDLE: begin
                if (level_s != '0) begin
                    pop_s = 1'b1;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                end else begin
                    tx_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s && idx_q == LAST_DATA) begin
                    idx_d = '0;
                    if (PARITY != PARITY_NONE) begin
                        state_d = ST_PAR;
                        tx_d    = par_q;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end
                end else if (bit_end_s) begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    tx_d = tx_q;
                end
            end
            ST_PAR: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
                end else begin
                    tx_d = par_q;
                end
            end
            ST_STOP: begin
                // Registered pulse: decided one cycle early so it lands on the final cycle.
                done_d = (idx_q == LAST_STOP) && (timer_q == per_q - 16'd2);
                tx_d   = 1'b1;
                if (bit_end_s && idx_q == LAST_STOP) begin
                    if (level_s != '0) begin
                        pop_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bit_end_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (pop_s) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            timer_d = 16'd0;
            idx_d   = '0;
            shift_d = fifo_rdata_s;
            par_d   = parity_bit(9'(fifo_rdata_s), PARITY);
            per_d   = clamp_div(baud_div, DIV);
        end else begin
            per_d = per_q;
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= 16'd0;
            per_q   <= MIN_DIV;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors decode the line.
module tb_uart_tx_fifo;

    typedef struct {
        logic [8:0] w;
        int         p;
        int         dw;
        int         par;
        logic       pbit;
        int         stops;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int gap_cnt     = 0;
    frame_t sb [4][$];

    logic [7:0]  data_a, data_b, data_d;
    logic [4:0]  data_c;
    logic        valid_a, valid_b, valid_c, valid_d;
    logic        ready_a, ready_b, ready_c, ready_d;
    logic [15:0] bd_a, bd_b, bd_c, bd_d;
    logic        tx_a, tx_b, tx_c, tx_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic [2:0]  level_a, level_b, level_c, level_d;
    logic        fd_a, fd_b, fd_c, fd_d;
    logic        tx_w [4];
    logic        fd_w [4];

    assign tx_w[0] = tx_a; assign tx_w[1] = tx_b; assign tx_w[2] = tx_c; assign tx_w[3] = tx_d;
    assign fd_w[0] = fd_a; assign fd_w[1] = fd_b; assign fd_w[2] = fd_c; assign fd_w[3] = fd_d;

    uart_tx_fifo #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .data(data_a), .valid(valid_a), .ready(ready_a),
        .baud_div(bd_a), .tx(tx_a), .busy(busy_a), .level(level_a), .frame_done(fd_a));
    uart_tx_fifo #(.DATA_W(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .data(data_b), .valid(valid_b), .ready(ready_b),
        .baud_div(bd_b), .tx(tx_b), .busy(busy_b), .level(level_b), .frame_done(fd_b));
    uart_tx_fifo #(.DATA_W(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .data(data_c), .valid(valid_c), .ready(ready_c),
        .baud_div(bd_c), .tx(tx_c), .busy(busy_c), .level(level_c), .frame_done(fd_c));
    uart_tx_fifo dut_d (
        .clk(clk), .rst_n(rst_n), .data(data_d), .valid(valid_d), .ready(ready_d),
        .baud_div(bd_d), .tx(tx_d), .busy(busy_d), .level(level_d), .frame_done(fd_d));

    // Cycles where dut_a holds queued data but is not transmitting.
    always @(negedge clk) begin
        if (rst_n && !busy_a && level_a != 3'd0) gap_cnt <= gap_cnt + 1;
    end

    function automatic logic exp_bit(input frame_t f, input int k);
        int b = k / f.p;
        if (b == 0) return 1'b0;
        if (b <= f.dw) return f.w[b-1];
        if (f.par != 0 && b == f.dw + 1) return f.pbit;
        return 1'b1;
    endfunction

    function automatic logic get_busy(input int id);
        case (id)
            0: return busy_a;
            1: return busy_b;
            2: return busy_c;
            default: return busy_d;
        endcase
    endfunction

    function automatic int get_level(input int id);
        case (id)
            0: return int'(level_a);
            1: return int'(level_b);
            2: return int'(level_c);
            default: return int'(level_d);
        endcase
    endfunction

    function automatic logic get_ready(input int id);
        case (id)
            0: return ready_a;
            1: return ready_b;
            2: return ready_c;
            default: return ready_d;
        endcase
    endfunction

    task automatic drive(input int id, input logic [8:0] w, input logic v);
        case (id)
            0: begin data_a = w[7:0]; valid_a = v; end
            1: begin data_b = w[7:0]; valid_b = v; end
            2: begin data_c = w[4:0]; valid_c = v; end
            default: begin data_d = w[7:0]; valid_d = v; end
        endcase
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [8:0] w, input int p, input int par,
                        input logic pbit, input int stops);
        frame_t f;
        @(negedge clk);
        drive(id, w, 1'b1);
        check($sformatf("ready_dut%0d", id), int'(get_ready(id)), 1);
        f.w = w; f.p = p; f.dw = (id == 2) ? 5 : 8; f.par = par; f.pbit = pbit; f.stops = stops;
        sb[id].push_back(f);
        @(posedge clk);
        #1;
        drive(id, w, 1'b0);
    endtask

    task automatic wait_idle(input int id, input int bound);
        int n = 0;
        repeat (2) @(negedge clk);
        while (n < bound && !(get_busy(id) == 1'b0 && sb[id].size() == 0 && get_level(id) == 0)) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_within_bound_dut%0d", id), int'(n < bound), 1);
    endtask

    task automatic monitor(input int id);
        frame_t f;
        int     len, bad_tx, bad_fd;
        logic   got_tx;
        bit     aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_w[id] === 1'b0) begin
                if (sb[id].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame dut%0d: start bit seen, none expected", id);
                    while (rst_n === 1'b1 && tx_w[id] === 1'b0) @(negedge clk);
                end else begin
                    f = sb[id].pop_front();
                    len = (1 + f.dw + ((f.par != 0) ? 1 : 0) + f.stops) * f.p;
                    bad_tx = -1; bad_fd = -1; aborted = 1'b0; got_tx = 1'b0;
                    for (int k = 0; k < len; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx_w[id] !== exp_bit(f, k) && bad_tx < 0) begin
                            bad_tx = k;
                            got_tx = tx_w[id];
                        end
                        if (fd_w[id] !== ((k == len - 1) ? 1'b1 : 1'b0) && bad_fd < 0) bad_fd = k;
                    end
                    if (!aborted) begin
                        vectors += 2;
                        if (bad_tx >= 0) begin
                            miscompares++;
                            $display("FAIL tx_wave dut%0d word 0x%0h: cycle %0d of %0d got %b, expected %b",
                                     id, f.w, bad_tx, len, got_tx, exp_bit(f, bad_tx));
                        end
                        if (bad_fd >= 0) begin
                            miscompares++;
                            $display("FAIL frame_done dut%0d word 0x%0h: wrong at cycle %0d, expected only at cycle %0d",
                                     id, f.w, bad_fd, len - 1);
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    initial begin
        logic [8:0] b2b_w [6];
        logic       b2b_p [6];
        int         gap_base;
        b2b_w = '{9'h001, 9'h003, 9'h007, 9'h00F, 9'h0FF, 9'h080};
        b2b_p = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(0, 9'h000, 1'b0); drive(1, 9'h000, 1'b0);
        drive(2, 9'h000, 1'b0); drive(3, 9'h000, 1'b0);
        bd_a = 16'd4; bd_b = 16'd3; bd_c = 16'd3; bd_d = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx_a), 1);
        check("reset_busy", int'(busy_a), 0);
        check("reset_level", int'(level_a), 0);
        check("reset_ready", int'(ready_a), 1);
        check("reset_frame_done", int'(fd_a), 0);
        check("reset_tx_b", int'(tx_b), 1);
        rst_n = 1'b1;

        // 8E1, P=4, 0xA5: 44-clock frame, tx falls one clock after the push.
        push(0, 9'h0A5, 4, 1, 1'b0, 1);
        @(negedge clk);
        check("latency_still_idle", int'(tx_a), 1);
        @(negedge clk);
        check("latency_tx_fall", int'(tx_a), 0);
        check("latency_busy", int'(busy_a), 1);
        wait_idle(0, 200);

        // 8O2, P=3, 0x00: parity 1, 36-clock frame.
        push(1, 9'h000, 3, 2, 1'b1, 2);
        wait_idle(1, 200);

        // Back-to-back into depth 4: five accepted, sixth refused, no gaps.
        gap_base = gap_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            data_a  = b2b_w[i][7:0];
            valid_a = 1'b1;
            check($sformatf("b2b_ready_%0d", i), int'(ready_a), (i < 5) ? 1 : 0);
            if (i < 5) sb[0].push_back('{w: b2b_w[i], p: 4, dw: 8, par: 1, pbit: b2b_p[i], stops: 1});
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
        check("b2b_level_full", int'(level_a), 4);
        wait_idle(0, 400);
        check("b2b_idle_gap_cycles", gap_cnt - gap_base, 1);
        check("b2b_level_drained", int'(level_a), 0);

        // baud_div=1 clamps to 2 clocks per bit.
        bd_a = 16'd1;
        push(0, 9'h03C, 2, 1, 1'b0, 1);
        wait_idle(0, 200);

        // Divisor change mid-frame only affects the following frame.
        bd_a = 16'd4;
        push(0, 9'h096, 4, 1, 1'b0, 1);
        repeat (10) @(negedge clk);
        bd_a = 16'd7;
        wait_idle(0, 200);
        push(0, 9'h001, 7, 1, 1'b1, 1);
        wait_idle(0, 200);
        bd_a = 16'd4;

        // 5N1: only the low five bits go out, 7*P clocks.
        push(2, 9'h0FF, 3, 0, 1'b0, 1);
        wait_idle(2, 200);

        // Defaults with baud_div=0: 434 clocks per bit.
        push(3, 9'h055, 434, 0, 1'b0, 1);
        wait_idle(3, 5000);

        // Reset in the middle of data bit 0 with a second word queued.
        push(0, 9'h05A, 4, 1, 1'b0, 1);
        push(0, 9'h033, 4, 1, 1'b0, 1);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", int'(tx_a), 1);
        check("midreset_busy", int'(busy_a), 0);
        check("midreset_level", int'(level_a), 0);
        check("midreset_ready", int'(ready_a), 1);
        sb[0].delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        push(0, 9'h033, 4, 1, 1'b0, 1);
        wait_idle(0, 200);

        check("scoreboard_empty", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
